airi5c_float_unpacker: RTL and testbench
========================================

// Module: airi5c_float_unpacker
// PURPOSE
//   Front end of the FPU operand path: splits a binary32 operand into sign, unbiased exponent and
//   24-bit significand, and raises the class flags (zero/inf/sNaN/qNaN/denormal) consumed by
//   the FCLASS classifier and the arithmetic units. Denormals are normalised iteratively, one
//   left shift per cycle, so every downstream unit sees a significand with bit 23 set.
// PARAMETERS
//   EXP_W  10  width of signed exponent output; must be >= 10 (covers -149..+128)
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   reset     in   1      synchronous, active-high reset
//   kill      in   1      abort current operation (pipeline flush)
//   load      in   1      start unpacking float_in; accepted only when busy=0
//   float_in  in   32     IEEE-754 binary32 operand, sampled on accepted load
//   sgn       out  1      sign bit
//   zero      out  1      operand is +/-0
//   inf       out  1      operand is +/-inf
//   sNaN      out  1      signalling NaN (exp=FF, frac!=0, frac[22]=0)
//   qNaN      out  1      quiet NaN (exp=FF, frac[22]=1)
//   denormal  out  1      operand was subnormal (exp=0, frac!=0)
//   exp_out   out  EXP_W  unbiased exponent, two's complement
//   man_out   out  24     significand incl. hidden bit
//   busy      out  1      normalisation in progress (state NORM)
//   ready     out  1      one-cycle pulse: outputs valid
// BEHAVIOUR
//   Reset (sync, high): state IDLE; all outputs 0. Priority: reset > kill > load.
//   States: IDLE, NORM. busy = (state==NORM).
//   Accepted load = load && !busy && !kill. At that edge (end of cycle 0) outputs are written:
//     sgn=float_in[31]; e=float_in[30:23]; f=float_in[22:0]; flags mutually exclusive.
//     normal (0<e<FF): exp_out=e-127, man_out={1,f}; ready=1 next cycle, stay IDLE.
//     zero (e=0,f=0):  exp_out=0, man_out=0, zero=1; ready=1, stay IDLE.
//     inf  (e=FF,f=0): exp_out=128, man_out={1,f}, inf=1; ready=1, stay IDLE.
//     NaN  (e=FF,f!=0): exp_out=128, man_out={1,f}, sNaN/qNaN per f[22]; ready=1, stay IDLE.
//     denormal (e=0,f!=0): denormal=1, exp_out=-126, man_out={0,f}; ready=0; go NORM.
//   NORM: each edge man_out<<=1 (LSB 0), exp_out-=1. When the shifted value has bit 23 set,
//     same edge sets ready=1 and returns to IDLE. k = leading zeros of {0,f}, 1..23.
//   Latency: load in cycle 0 -> ready high in cycle 1+k (k=0 for non-denormal). Throughput:
//     new load accepted in the same cycle ready is high.
//   ready: one-cycle pulse, 0 in all other cycles. Outputs hold after ready until next accepted
//     load, kill or reset.
//   load while busy: ignored, no effect on state or outputs (requester must wait).
//   kill (any state): next edge state=IDLE, all outputs 0, ready=0; simultaneous load dropped.
//   Mid-NORM reset or kill: shift abandoned, no ready pulse for the aborted operand.
//   Exponent arithmetic in EXP_W-bit two's complement; min value -149 (f=1), no wrap.
// TESTING
//   load 0x3F800000 -> cycle 1: ready=1, sgn=0, exp_out=0, man_out=0x800000, all flags 0
//   load 0x80000000 -> cycle 1: ready=1, sgn=1, zero=1, man_out=0, exp_out=0
//   load 0x00400000 -> busy cycle 1, ready cycle 2: denormal=1, exp_out=-127, man_out=0x800000
//   load 0x00000001 -> ready only in cycle 24: exp_out=-149, man_out=0x800000; load pulsed in
//     cycles 5..10 ignored (outputs unaffected)
//   load 0xFF800000 -> inf=1,sgn=1,exp_out=128; 0x7FA00000 -> sNaN=1; 0x7FC00000 -> qNaN=1
//   load 0x00000001, kill in cycle 5 -> cycle 6 all outputs 0, busy=0, no ready pulse; then
//     load 0x40000000 in cycle 6 -> cycle 7 ready=1, exp_out=1, man_out=0x800000

Source files
------------

// File: rtl/airi5c_float_unpacker.sv
// ---------------------------------------------------------------------------
// airi5c_float_unpacker
//   Front end of the FPU operand path. Splits an IEEE-754 binary32 operand
//   into sign, unbiased exponent and 24-bit significand, and raises the
//   mutually exclusive class flags (zero / inf / sNaN / qNaN / denormal).
//   Subnormal operands are normalised one left shift per cycle, so every
//   consumer sees a significand with bit 23 set (zero excepted).
//
// Parameters
//   EXP_W     width of the two's-complement exponent output (>= 10)
//
// Ports
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   kill      abort current operation; clears all outputs on the next edge
//   load      start unpacking float_in; accepted only while not busy
//   float_in  binary32 operand, sampled on an accepted load
//   sgn, zero, inf, sNaN, qNaN, denormal   sign and class flags
//   exp_out   unbiased exponent, two's complement
//   man_out   significand including the hidden bit
//   busy      normalisation of a subnormal in progress
//   ready     one-cycle pulse: outputs valid
// ---------------------------------------------------------------------------
module airi5c_float_unpacker #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             kill,
  input  logic             load,
  input  logic [31:0]      float_in,
  output logic             sgn,
  output logic             zero,
  output logic             inf,
  output logic             sNaN,
  output logic             qNaN,
  output logic             denormal,
  output logic [EXP_W-1:0] exp_out,
  output logic [23:0]      man_out,
  output logic             busy,
  output logic             ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

  // Everything an accepted load writes into the output registers.
  typedef struct packed {
    logic             sgn;
    logic             zero;
    logic             inf;
    logic             snan;
    logic             qnan;
    logic             denormal;
    logic [EXP_W-1:0] exp;
    logic [23:0]      man;
    logic             norm_req;
  } unpack_t;

  localparam logic [EXP_W-1:0] EXP_BIAS_C   = EXP_W'(10'd127);
  localparam logic [EXP_W-1:0] EXP_SPECIAL_C = EXP_W'(10'd128);
  // Subnormals carry the minimum normal exponent before normalisation.
  localparam logic [EXP_W-1:0] EXP_DENORM_C = EXP_W'(10'd0) - EXP_W'(10'd126);
  localparam logic [EXP_W-1:0] EXP_ONE_C    = EXP_W'(10'd1);

  // Classify a binary32 operand and produce its unpacked fields.
  function automatic unpack_t unpack_f(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] f;
    unpack_t     u;
    e     = x[30:23];
    f     = x[22:0];
    u     = '0;
    u.sgn = x[31];
    if (e == 8'h00) begin
      if (f == 23'd0) begin
        u.zero = 1'b1;
      end else begin
        u.denormal = 1'b1;
        u.exp      = EXP_DENORM_C;
        u.man      = {1'b0, f};
        u.norm_req = 1'b1;
      end
    end else if (e == 8'hFF) begin
      u.exp = EXP_SPECIAL_C;
      u.man = {1'b1, f};
      if (f == 23'd0) begin
        u.inf = 1'b1;
      end else if (f[22]) begin
        u.qnan = 1'b1;
      end else begin
        u.snan = 1'b1;
      end
    end else begin
      u.exp = {{(EXP_W-8){1'b0}}, e} - EXP_BIAS_C;
      u.man = {1'b1, f};
    end
    return u;
  endfunction

  state_t      state_r;
  logic        load_acc_s;
  logic [23:0] man_shift_s;
  unpack_t     unpack_s;

  assign load_acc_s  = load && (state_r == IDLE) && !kill;
  assign man_shift_s = {man_out[22:0], 1'b0};
  assign unpack_s    = unpack_f(float_in);
  assign busy        = (state_r == NORM);

  // Operand capture, iterative normalisation and the ready pulse.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      state_r  <= IDLE;
      sgn      <= 1'b0;
      zero     <= 1'b0;
      inf      <= 1'b0;
      sNaN     <= 1'b0;
      qNaN     <= 1'b0;
      denormal <= 1'b0;
      exp_out  <= '0;
      man_out  <= 24'd0;
      ready    <= 1'b0;
    end else if (load_acc_s) begin
      sgn      <= unpack_s.sgn;
      zero     <= unpack_s.zero;
      inf      <= unpack_s.inf;
      sNaN     <= unpack_s.snan;
      qNaN     <= unpack_s.qnan;
      denormal <= unpack_s.denormal;
      exp_out  <= unpack_s.exp;
      man_out  <= unpack_s.man;
      ready    <= !unpack_s.norm_req;
      state_r  <= unpack_s.norm_req ? NORM : IDLE;
    end else if (state_r == NORM) begin
      // Shift and decrement together; finish on the edge that sets bit 23.
      man_out <= man_shift_s;
      exp_out <= exp_out - EXP_ONE_C;
      if (man_shift_s[23]) begin
        ready   <= 1'b1;
        state_r <= IDLE;
      end else begin
        ready   <= 1'b0;
        state_r <= NORM;
      end
    end else begin
      ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_airi5c_float_unpacker.sv
module tb_airi5c_float_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        kill;
  logic        load;
  logic [31:0] float_in;
  logic        sgn, zero, inf, sNaN, qNaN, denormal;
  logic [9:0]  exp_out;
  logic [23:0] man_out;
  logic        busy, ready;

  int n_cmp = 0;
  int n_err = 0;

  airi5c_float_unpacker #(.EXP_W(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .kill     (kill),
    .load     (load),
    .float_in (float_in),
    .sgn      (sgn),
    .zero     (zero),
    .inf      (inf),
    .sNaN     (sNaN),
    .qNaN     (qNaN),
    .denormal (denormal),
    .exp_out  (exp_out),
    .man_out  (man_out),
    .busy     (busy),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Whole output vector: {ready, busy, sgn, zero, inf, sNaN, qNaN, denormal, exp, man}.
  task automatic chk_all(input string tag, input logic rdy, input logic bsy,
                         input logic [5:0] flags, input logic [9:0] e, input logic [23:0] m);
    chk(tag, {22'd0, ready, busy, sgn, zero, inf, sNaN, qNaN, denormal, exp_out, man_out},
             {22'd0, rdy, bsy, flags, e, m});
  endtask

  task automatic do_load(input logic [31:0] v);
    load     = 1'b1;
    float_in = v;
    step();
    load     = 1'b0;
  endtask

  initial begin
    logic [23:0] m_exp;
    logic [9:0]  e_exp;
    reset = 1'b1; kill = 1'b0; load = 1'b0; float_in = 32'd0;
    step(); step();
    chk_all("reset", 1'b0, 1'b0, 6'b000000, 10'h000, 24'h000000);
    reset = 1'b0;

    // 1.0: exponent 0, hidden bit set, ready one cycle later.
    do_load(32'h3F800000);
    chk_all("one", 1'b1, 1'b0, 6'b000000, 10'h000, 24'h800000);
    step();
    chk_all("one_hold", 1'b0, 1'b0, 6'b000000, 10'h000, 24'h800000);

    // -0.0
    do_load(32'h80000000);
    chk_all("neg_zero", 1'b1, 1'b0, 6'b110000, 10'h000, 24'h000000);

    // Subnormal with one leading zero: exp -126 (0x382) then -127 (0x381).
    do_load(32'h00400000);
    chk_all("den1_c1", 1'b0, 1'b1, 6'b000001, 10'h382, 24'h400000);
    step();
    chk_all("den1_c2", 1'b1, 1'b0, 6'b000001, 10'h381, 24'h800000);

    // Smallest subnormal: 23 shifts, loads in cycles 5..10 ignored.
    do_load(32'h00000001);
    for (int i = 1; i <= 23; i++) begin
      m_exp = 24'd1 << (i - 1);
      e_exp = 10'h382 - 10'(i - 1);
      chk_all($sformatf("min_den_c%0d", i), 1'b0, 1'b1, 6'b000001, e_exp, m_exp);
      load     = (i >= 5 && i <= 10);
      float_in = 32'h3F800000;
      step();
    end
    load = 1'b0;
    // exp -149 = 0x36B
    chk_all("min_den_c24", 1'b1, 1'b0, 6'b000001, 10'h36B, 24'h800000);

    // -inf, then ready drops back to 0.
    do_load(32'hFF800000);
    chk_all("neg_inf", 1'b1, 1'b0, 6'b101000, 10'h080, 24'h800000);
    step();
    chk_all("inf_pulse", 1'b0, 1'b0, 6'b101000, 10'h080, 24'h800000);

    do_load(32'h7FA00000);
    chk_all("snan", 1'b1, 1'b0, 6'b000100, 10'h080, 24'hA00000);
    do_load(32'h7FC00000);
    chk_all("qnan", 1'b1, 1'b0, 6'b000010, 10'h080, 24'hC00000);

    // Largest normal: exp 127, all fraction bits.
    do_load(32'h7F7FFFFF);
    chk_all("max_norm", 1'b1, 1'b0, 6'b000000, 10'h07F, 24'hFFFFFF);

    // Kill in the middle of normalisation.
    do_load(32'h00000001);
    step(); step(); step(); step();           // now in cycle 5
    chk_all("kill_pre", 1'b0, 1'b1, 6'b000001, 10'h37E, 24'h000010);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk_all("kill_c6", 1'b0, 1'b0, 6'b000000, 10'h000, 24'h000000);
    do_load(32'h40000000);
    chk_all("after_kill", 1'b1, 1'b0, 6'b000000, 10'h001, 24'h800000);

    // Load in the ready cycle is accepted (back-to-back throughput).
    do_load(32'h80400000);
    chk_all("b2b_c1", 1'b0, 1'b1, 6'b100001, 10'h382, 24'h400000);
    step();
    chk_all("b2b_c2", 1'b1, 1'b0, 6'b100001, 10'h381, 24'h800000);

    // Kill beats a simultaneous load.
    kill = 1'b1;
    do_load(32'h3F800000);
    kill = 1'b0;
    chk_all("kill_vs_load", 1'b0, 1'b0, 6'b000000, 10'h000, 24'h000000);

    // Reset in the middle of normalisation: no ready pulse afterwards.
    do_load(32'h00000100);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_all("reset_mid", 1'b0, 1'b0, 6'b000000, 10'h000, 24'h000000);
    step(); step();
    chk_all("reset_no_ready", 1'b0, 1'b0, 6'b000000, 10'h000, 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
